// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package mc_pkg;

   // Controller states
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECUTER = 4'd7,
      EXECUTEI = 4'd8,
      ALUWB    = 4'd9,
      BEQ      = 4'd10,
      JAL      = 4'd11,
      TRAP     = 4'd12
   } mc_state_e;

   // Supported opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ResultSrc encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc encodings
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALUOp encodings handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUControl encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Moore control word held in flops; mem_ready/Zero gating is applied at the outputs
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       fetch_en;       // IRWrite and PCWrite once the fetch completes
      logic       pc_jump;        // unconditional PC load
      logic       branch;         // PC load qualified by Zero
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       done;           // unconditional retire pulse
      logic       done_on_ready;  // retire when the store completes
      logic       illegal;
   } mc_ctrl_t;

   // Control word produced by each state
   function automatic mc_ctrl_t state_ctrl(input mc_state_e st);
      mc_ctrl_t c;
      c = '0;
      case (st)
         FETCH: begin
            c.mem_req    = 1'b1;
            c.fetch_en   = 1'b1;
            c.result_src = RES_ALURESULT;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
         end
         DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         MEMREAD: begin
            c.mem_req    = 1'b1;
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         MEMWRITE: begin
            c.mem_req       = 1'b1;
            c.mem_write     = 1'b1;
            c.adr_src       = 1'b1;
            c.done_on_ready = 1'b1;
         end
         EXECUTER: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_RD2;
            c.alu_op    = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         BEQ: begin
            c.alu_src_a  = SRCA_RD1;
            c.alu_src_b  = SRCB_RD2;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
            c.done       = 1'b1;
         end
         JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_jump    = 1'b1;
         end
         TRAP: begin
            c.illegal = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction fields onto ALUControl.
module aludec
   import mc_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control
);

   // Select the ALU operation; subtract only for R-type with funct7[5] set
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000: begin
                  if (op5 && funct7b5) begin
                     alu_control = ALU_SUB;
                  end else begin
                     alu_control = ALU_ADD;
                  end
               end
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
module mc_controller
   import mc_pkg::*;
#(
   parameter int RESET_TO_IDLE = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic        instr_done,
   output logic        illegal
);

   // Only the idle boot path exists; the parameter is kept for a future boot vector.
   localparam mc_state_e RESET_STATE = (RESET_TO_IDLE == 32'sd1) ? IDLE : IDLE;

   mc_state_e  state_q, state_d;
   mc_ctrl_t   ctrl_q, ctrl_d;
   logic [1:0] imm_src_s;
   logic [2:0] alu_control_s;
   logic       unused_instr_s;

   // Next-state selection from the current state, opcode and memory handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            case (Instr[6:0])
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:              state_d = EXECUTER;
               OP_I:              state_d = EXECUTEI;
               OP_BRANCH:         state_d = BEQ;
               OP_JAL:            state_d = JAL;
               default:           state_d = TRAP;
            endcase
         end
         MEMADR: begin
            if (Instr[5]) begin
               state_d = MEMWRITE;
            end else begin
               state_d = MEMREAD;
            end
         end
         MEMREAD: begin
            if (mem_ready) begin
               state_d = MEMWB;
            end else begin
               state_d = MEMREAD;
            end
         end
         MEMWB: state_d = FETCH;
         MEMWRITE: begin
            if (mem_ready) begin
               state_d = FETCH;
            end else begin
               state_d = MEMWRITE;
            end
         end
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BEQ:      state_d = FETCH;
         JAL:      state_d = ALUWB;
         TRAP:     state_d = TRAP;
         default:  state_d = IDLE;
      endcase
   end

   // Control word for the state being entered, so the outputs come straight from flops
   always_comb begin
      ctrl_d = state_ctrl(state_d);
   end

   // State and control-word registers; reset clears every enable immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Immediate format from the opcode, independent of state
   always_comb begin
      imm_src_s = IMM_I;
      case (Instr[6:0])
         OP_LOAD, OP_I: imm_src_s = IMM_I;
         OP_STORE:      imm_src_s = IMM_S;
         OP_BRANCH:     imm_src_s = IMM_B;
         OP_JAL:        imm_src_s = IMM_J;
         default:       imm_src_s = IMM_I;
      endcase
   end

   aludec u_aludec (
      .op5         (Instr[5]),
      .funct3      (Instr[14:12]),
      .funct7b5    (Instr[30]),
      .alu_op      (ctrl_q.alu_op),
      .alu_control (alu_control_s)
   );

   // Register, immediate and destination fields are consumed by the datapath, not here.
   assign unused_instr_s = ^{Instr[31], Instr[29:15], Instr[11:7]};

   assign mem_req    = ctrl_q.mem_req;
   assign MemWrite   = ctrl_q.mem_write;
   assign AdrSrc     = ctrl_q.adr_src;
   assign IRWrite    = ctrl_q.fetch_en & mem_ready;
   assign PCWrite    = (ctrl_q.fetch_en & mem_ready) | ctrl_q.pc_jump | (ctrl_q.branch & Zero);
   assign RegWrite   = ctrl_q.reg_write;
   assign ResultSrc  = ctrl_q.result_src;
   assign ALUSrcA    = ctrl_q.alu_src_a;
   assign ALUSrcB    = ctrl_q.alu_src_b;
   assign ImmSrc     = imm_src_s;
   assign ALUControl = alu_control_s;
   assign instr_done = ctrl_q.done | (ctrl_q.done_on_ready & mem_ready);
   assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller.
module tb_mc_controller;

   logic        clk;
   logic        rst_n;
   logic [31:0] Instr;
   logic        Zero;
   logic        mem_ready;
   logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;
   logic        instr_done, illegal;

   int tests_run;
   int tests_failed;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_LW   = 32'h00802283;
   localparam logic [31:0] I_SW   = 32'h00502223;
   localparam logic [31:0] I_ADDI = 32'h40000093;
   localparam logic [31:0] I_BEQ  = 32'hFE108EE3;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic        rdy;
      logic        zero;
      logic [18:0] exp;
   } vec_t;

   vec_t vecs[$];

   mc_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Instr      (Instr),
      .Zero       (Zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed output word: {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,instr_done,illegal}
   function automatic logic [18:0] ex(input logic mr, input logic mw, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic dn, input logic il);
      return {mr, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu, dn, il};
   endfunction

   function automatic logic [18:0] outs();
      return {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
              ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addv(input string tag, input logic [31:0] instr, input logic rdy,
                       input logic zero, input logic [18:0] exp);
      vec_t v;
      v.tag = tag; v.instr = instr; v.rdy = rdy; v.zero = zero; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // add x3,x1,x2
      addv("add_fetch",  I_ADD, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("add_decode", I_ADD, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      addv("add_exec",   I_ADD, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
      addv("add_wb",     I_ADD, 1'b1, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // lw x5,8(x0): two fetch waits (Zero high must not leak into PCWrite), one read wait
      addv("lw_fetch_w1", I_LW, 1'b0, 1'b1, ex(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("lw_fetch_w2", I_LW, 1'b0, 1'b0, ex(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("lw_fetch",    I_LW, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("lw_decode",   I_LW, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      addv("lw_memadr",   I_LW, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
      addv("lw_rd_wait",  I_LW, 1'b0, 1'b0, ex(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
      addv("lw_rd",       I_LW, 1'b1, 1'b0, ex(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
      addv("lw_memwb",    I_LW, 1'b1, 1'b0, ex(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));
      // sw x5,4(x0) with one write wait
      addv("sw_fetch",    I_SW, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      addv("sw_decode",   I_SW, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
      addv("sw_memadr",   I_SW, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
      addv("sw_wr_wait",  I_SW, 1'b0, 1'b0, ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
      addv("sw_wr",       I_SW, 1'b1, 1'b0, ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1,0));
      // addi x1,x0,1024: Instr[30]=1 but no subtract for I-type
      addv("addi_fetch",  I_ADDI, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("addi_decode", I_ADDI, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      addv("addi_exec",   I_ADDI, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
      addv("addi_wb",     I_ADDI, 1'b1, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // sub x3,x1,x2
      addv("sub_fetch",   I_SUB, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("sub_decode",  I_SUB, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      addv("sub_exec",    I_SUB, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
      addv("sub_wb",      I_SUB, 1'b1, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // beq taken then not taken
      addv("beq1_fetch",  I_BEQ, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      addv("beq1_decode", I_BEQ, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      addv("beq_taken",   I_BEQ, 1'b1, 1'b1, ex(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));
      addv("beq2_fetch",  I_BEQ, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      addv("beq2_decode", I_BEQ, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      addv("beq_not",     I_BEQ, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));
      // jal x1,8
      addv("jal_fetch",   I_JAL, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0,0));
      addv("jal_decode",  I_JAL, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0));
      addv("jal_jump",    I_JAL, 1'b1, 1'b0, ex(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
      addv("jal_wb",      I_JAL, 1'b1, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,1,0));
      // unsupported opcode heads for TRAP
      addv("ill_fetch",   I_ILL, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      addv("ill_decode",  I_ILL, 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));

      // Reset held for 3 cycles, then IDLE
      rst_n = 1'b0; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("reset_outs", 32'(outs()), 32'(ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)));
      rst_n = 1'b1;
      #1 chk("idle_outs", 32'(outs()), 32'(ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)));

      // Table: one record per cycle, starting in FETCH
      foreach (vecs[i]) begin
         @(negedge clk);
         Instr = vecs[i].instr; mem_ready = vecs[i].rdy; Zero = vecs[i].zero;
         #1 chk(vecs[i].tag, 32'(outs()), 32'(vecs[i].exp));
      end

      // TRAP is terminal and silent regardless of mem_ready/Zero
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         Instr = I_ILL; mem_ready = k[0]; Zero = 1'b1;
         #1;
         chk("trap_illegal", 32'(illegal), 32'd1);
         chk("trap_quiet", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_done}), 32'd0);
      end

      // Reset pulse clears the sticky flag and restarts from IDLE
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("trap_reset_clear", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("trap_idle", 32'(outs()), 32'(ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0)));

      // Store aborted by reset while waiting in MEMWRITE
      @(negedge clk);
      Instr = I_SW; mem_ready = 1'b1; Zero = 1'b0;
      #1 chk("rst_sw_fetch", 32'(outs()), 32'(ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)));
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1 chk("rst_sw_wr", 32'({mem_req, MemWrite}), 32'd3);
      #2 rst_n = 1'b0;
      #1 chk("rst_sw_drop", 32'({mem_req, MemWrite, instr_done}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      #1 chk("rst_sw_idle", 32'(outs()), 32'(ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0)));
      @(negedge clk);
      #1 chk("rst_sw_refetch", 32'(outs()), 32'(ex(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0)));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
